// File: rtl/tk_sync_rr_arbiter.sv
// Clocked round-robin arbiter sharing one four-phase resource channel among N
// four-phase requesters arriving from a self-timed domain through synchronisers.

module tk_sync_rr_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chain <= '0;
      else        chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

module tk_sync_rr_arbiter #(
   parameter int N           = 4,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255,
   localparam int SW         = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  ack,
   output logic          res_req,
   input  logic          res_ack,
   output logic [SW-1:0] sel,
   output logic          busy,
   output logic          err
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, REQ_UP, ACK_UP, REQ_DN} state_t;

   state_t        state, state_nxt;
   logic [N-1:0]  req_s, ack_nxt;
   logic          res_ack_s, res_req_nxt, found, wd_active, wd_hit;
   logic [SW-1:0] ptr, ptr_nxt, sel_nxt, winner;
   logic [CW-1:0] wd_cnt, wd_nxt;
   int            scan;

   tk_sync_rr_sync #(.STAGES(SYNC_STAGES)) u_req_sync [N-1:0] (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (req),
      .q     (req_s)
   );

   tk_sync_rr_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (res_ack),
      .q     (res_ack_s)
   );

   // First set request scanning upward from ptr, wrapping at N.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      scan   = 0;
      for (int k = 0; k < N; k++) begin
         scan = int'(ptr) + k;
         if (scan >= N) scan = scan - N;
         if (!found && req_s[scan]) begin
            found  = 1'b1;
            winner = SW'(scan);
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      sel_nxt     = sel;
      ack_nxt     = ack;
      res_req_nxt = res_req;
      ptr_nxt     = ptr;
      case (state)
         IDLE: if (found) begin
            state_nxt   = REQ_UP;
            sel_nxt     = winner;
            res_req_nxt = 1'b1;
         end
         REQ_UP: if (res_ack_s) begin
            state_nxt    = ACK_UP;
            ack_nxt      = '0;
            ack_nxt[sel] = 1'b1;
         end
         ACK_UP: if (!req_s[sel]) begin
            state_nxt   = REQ_DN;
            res_req_nxt = 1'b0;
         end
         REQ_DN: if (!res_ack_s) begin
            state_nxt = IDLE;
            ack_nxt   = '0;
            ptr_nxt   = (int'(sel) == N - 1) ? '0 : sel + 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Watchdog only runs while waiting on the resource; it restarts on every
   // state change and saturates so err cannot be re-armed by wraparound.
   always_comb begin
      wd_active = (TIMEOUT != 0) && ((state == REQ_UP) || (state == REQ_DN));
      if (state_nxt != state)              wd_nxt = '0;
      else if (wd_active && wd_cnt != WD_MAX) wd_nxt = wd_cnt + 1'b1;
      else                                 wd_nxt = wd_cnt;
      wd_hit = wd_active && (state_nxt == state) && (wd_nxt == WD_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         sel     <= '0;
         ack     <= '0;
         res_req <= 1'b0;
         ptr     <= '0;
         busy    <= 1'b0;
         err     <= 1'b0;
         wd_cnt  <= '0;
      end else begin
         state   <= state_nxt;
         sel     <= sel_nxt;
         ack     <= ack_nxt;
         res_req <= res_req_nxt;
         ptr     <= ptr_nxt;
         busy    <= (state_nxt != IDLE);
         err     <= err | wd_hit;
         wd_cnt  <= wd_nxt;
      end
   end

endmodule

// File: tb/tb_tk_sync_rr_arbiter.sv
// Directed bench for tk_sync_rr_arbiter: main instance (TIMEOUT=255) driven by
// requester/resource models, plus a TIMEOUT=8 instance for the watchdog.

module tb_tk_sync_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n, res_ack;
   logic [3:0] req, ack;
   logic       res_req, busy, err;
   logic [1:0] sel;

   logic       rst_w, res_ack_w;
   logic [3:0] req_w, ack_w;
   logic       res_req_w, busy_w, err_w;
   logic [1:0] sel_w;

   int passed = 0, total = 0;
   int viol = 0, rcnt = 0, res_dly = 3;
   int grants[$];
   int exp_order[6] = '{0, 1, 2, 3, 0, 1};
   logic [3:0] prev_ack = '0, auto_rq = '0, hold = '0;

   always #5 clk = ~clk;

   tk_sync_rr_arbiter #(.N(4), .SYNC_STAGES(2), .TIMEOUT(255)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .res_req(res_req),
      .res_ack(res_ack), .sel(sel), .busy(busy), .err(err)
   );

   tk_sync_rr_arbiter #(.N(4), .SYNC_STAGES(2), .TIMEOUT(8)) dut_wd (
      .clk(clk), .rst_n(rst_w), .req(req_w), .ack(ack_w), .res_req(res_req_w),
      .res_ack(res_ack_w), .sel(sel_w), .busy(busy_w), .err(err_w)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // One clock: record grants, then requesters drop on ack / re-raise when
   // auto, and the resource mirrors res_req after res_dly cycles.
   task automatic step();
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++)
         if (ack[i] && !prev_ack[i]) grants.push_back(i);
      if ($countones(ack) > 1) viol++;
      prev_ack = ack;
      for (int i = 0; i < 4; i++) begin
         if (ack[i] && !hold[i])       req[i] = 1'b0;
         else if (!ack[i] && auto_rq[i]) req[i] = 1'b1;
      end
      if (res_ack !== res_req) begin
         rcnt++;
         if (rcnt >= res_dly) begin
            res_ack = res_req;
            rcnt    = 0;
         end
      end else rcnt = 0;
   endtask

   task automatic drain();
      for (int t = 0; t < 400 && (req != 0 || busy || ack != 0); t++) step();
      chk("drain_busy", busy, 1'b0);
      chk("drain_ack", ack, 4'b0000);
   endtask

   initial begin
      rst_n = 1'b0; req = '0; res_ack = 1'b0;
      rst_w = 1'b0; req_w = '0; res_ack_w = 1'b0;
      #3;
      chk("rst_ack", ack, 4'b0000);
      chk("rst_res_req", res_req, 1'b0);
      chk("rst_sel", sel, 2'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      step(); step();

      // Single request: res_req rises SYNC_STAGES+1 edges after req[2]
      req[2] = 1'b1;
      step(); step();
      chk("single_res_req_early", res_req, 1'b0);
      step();
      chk("single_res_req", res_req, 1'b1);
      chk("single_sel", sel, 2'd2);
      chk("single_busy", busy, 1'b1);
      for (int t = 0; t < 50 && !res_ack; t++) step();
      chk("single_res_ack", res_ack, 1'b1);
      step(); step();
      chk("single_ack_early", ack, 4'b0000);
      step();
      chk("single_ack", ack, 4'b0100);
      for (int t = 0; t < 100 && (ack != 0 || busy); t++) step();
      chk("single_done_ack", ack, 4'b0000);
      chk("single_done_busy", busy, 1'b0);
      chk("single_ptr", dut.ptr, 2'd3);

      // Wrap and fairness from ptr=3 with req[0] and req[3], 3 re-raising
      grants.delete();
      auto_rq = 4'b1001; req = 4'b1001;
      for (int t = 0; t < 600 && grants.size() < 3; t++) step();
      auto_rq = 4'b0000;
      chk("wrap_count", grants.size() >= 3, 1'b1);
      chk("wrap_g0", grants.size() > 0 ? grants[0] : 99, 3);
      chk("wrap_g1", grants.size() > 1 ? grants[1] : 99, 0);
      chk("wrap_g2", grants.size() > 2 ? grants[2] : 99, 3);
      drain();

      // Late resource: res_ack 20 cycles after res_req, no watchdog trip
      res_dly = 20;
      req[1] = 1'b1;
      for (int t = 0; t < 20 && !res_req; t++) step();
      chk("late_res_req", res_req, 1'b1);
      for (int t = 0; t < 100 && !res_ack; t++) step();
      chk("late_err_wait", err, 1'b0);
      step(); step();
      chk("late_ack_early", ack, 4'b0000);
      step();
      chk("late_ack", ack, 4'b0010);
      drain();
      chk("late_err_done", err, 1'b0);

      // Reset in ACK_UP with ack[1] high
      res_dly = 3; hold = 4'b0010; req[1] = 1'b1;
      for (int t = 0; t < 100 && !ack[1]; t++) step();
      chk("mid_pre_ack", ack, 4'b0010);
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("mid_ack", ack, 4'b0000);
      chk("mid_res_req", res_req, 1'b0);
      chk("mid_busy", busy, 1'b0);
      chk("mid_sel", sel, 2'd0);
      req = '0; hold = '0; res_ack = 1'b0; rcnt = 0; prev_ack = '0;
      @(negedge clk) rst_n = 1'b1;
      step(); step(); step(); step();
      chk("post_ack", ack, 4'b0000);
      chk("post_res_req", res_req, 1'b0);
      chk("post_busy", busy, 1'b0);
      chk("post_sel", sel, 2'd0);

      // All four requesting continuously from ptr=0
      grants.delete(); viol = 0;
      auto_rq = 4'b1111; req = 4'b1111;
      for (int t = 0; t < 2000 && grants.size() < 6; t++) step();
      auto_rq = 4'b0000;
      chk("rr_count", grants.size() >= 6, 1'b1);
      for (int i = 0; i < 6; i++)
         chk($sformatf("rr_g%0d", i), grants.size() > i ? grants[i] : 99, exp_order[i]);
      drain();
      chk("rr_onehot", viol, 0);

      // Watchdog, TIMEOUT=8, resource never answers
      @(negedge clk) rst_w = 1'b1;
      req_w = 4'b0001;
      for (int t = 0; t < 20 && !res_req_w; t++) step();
      chk("wd_res_req", res_req_w, 1'b1);
      for (int i = 0; i < 7; i++) step();
      chk("wd_err_early", err_w, 1'b0);
      step();
      chk("wd_err", err_w, 1'b1);
      chk("wd_busy", busy_w, 1'b1);
      for (int i = 0; i < 10; i++) step();
      chk("wd_err_sticky", err_w, 1'b1);
      chk("wd_still_requp", {ack_w, res_req_w}, 5'b00001);
      #2 rst_w = 1'b0;
      #1;
      chk("wd_err_rst", err_w, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
